// File: rtl/dumbrv_pkg.sv
// Shared encodings for the dumbrv memory arbiter: LSU opcode fields, access sizes, arbiter states.
package dumbrv_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned OP_W        = 4;
    localparam int unsigned DREG_W      = 4;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned OP_STORE    = 3;
    localparam int unsigned OP_UNSIGNED = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MEM_FETCH = 2'd1,
        ST_MEM_LSU   = 2'd2,
        ST_RESP      = 2'd3
    } arb_state_e;

    // Byte-lane mask of an access right-aligned in the word; unknown sizes act as word.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dumbrv_mem_align.sv
// Store lane shifting/masking for the incoming request and load extract/extend for the returning word.
module dumbrv_mem_align
    import dumbrv_pkg::*;
(
    input  logic [1:0]        st_size,
    input  logic [1:0]        st_lo,
    input  logic [DATA_W-1:0] st_data,
    output logic [3:0]        st_wmask,
    output logic [DATA_W-1:0] st_wdata,
    output logic              st_misaligned,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    input  logic [1:0]        ld_lo,
    input  logic [DATA_W-1:0] ld_word,
    output logic [DATA_W-1:0] ld_data
);

    logic [DATA_W-1:0] ld_shifted;

    always_comb begin
        st_misaligned = is_misaligned(st_size, st_lo);
        st_wmask      = 4'(size_mask(st_size) << st_lo);
        st_wdata      = st_data << {st_lo, 3'b000};

        ld_shifted = ld_word >> {ld_lo, 3'b000};
        case (ld_size)
            SZ_BYTE: ld_data = ld_unsigned ? {24'h0, ld_shifted[7:0]}
                                           : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_HALF: ld_data = ld_unsigned ? {16'h0, ld_shifted[15:0]}
                                           : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/dumbrv_mem_arb.sv
// Arbitrates the single memory port between instruction fetch and LSU, LSU-first with a
// bounded starvation limit for fetch; returns tagged load results and drops stale fetches.
module dumbrv_mem_arb
    import dumbrv_pkg::*;
#(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    input  logic              fetch_flush_i,
    output logic              fetch_done_o,
    output logic [DATA_W-1:0] fetch_data_o,
    input  logic              lsu_valid_i,
    input  logic [OP_W-1:0]   lsu_opcode_i,
    input  logic [31:0]       lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    input  logic [DREG_W-1:0] lsu_dreg_i,
    output logic              lsu_accept_o,
    output logic              lsu_rvalid_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic [DREG_W-1:0] lsu_rdreg_o,
    output logic              lsu_err_o,
    output logic [DREG_W-1:0] lsu_busy_dreg_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_wmask_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              drop_q;
    logic              is_fetch_q;
    logic              is_store_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [1:0]        lo_q;
    logic [DREG_W-1:0] dreg_q;
    logic [DREG_W-1:0] busy_dreg_q;
    logic              lsu_rvalid_q;
    logic              lsu_err_q;
    logic [DATA_W-1:0] lsu_rdata_q;
    logic [DATA_W-1:0] fetch_data_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-3:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_wmask_q;

    logic              lsu_sel_c;
    logic              fetch_sel_c;
    logic              in_mem_c;
    logic [3:0]        st_wmask;
    logic [DATA_W-1:0] st_wdata;
    logic              st_misaligned;
    logic [DATA_W-1:0] ld_data;
    logic              unused_bits;

    assign unused_bits = ^{lsu_addr_i[31:ADDR_W], fetch_addr_i[1:0]};

    dumbrv_mem_align u_align (
        .st_size       (lsu_opcode_i[1:0]),
        .st_lo         (lsu_addr_i[1:0]),
        .st_data       (lsu_data_i),
        .st_wmask      (st_wmask),
        .st_wdata      (st_wdata),
        .st_misaligned (st_misaligned),
        .ld_size       (size_q),
        .ld_unsigned   (uns_q),
        .ld_lo         (lo_q),
        .ld_word       (mem_rdata_i),
        .ld_data       (ld_data)
    );

    // IDLE grant selection: LSU wins unless fetch has waited through STARVE_LIMIT LSU grants.
    always_comb begin
        lsu_sel_c   = 1'b0;
        fetch_sel_c = 1'b0;
        if (state_q == ST_IDLE) begin
            if (lsu_valid_i && ((cnt_q < CNT_W'(STARVE_LIMIT)) || !fetch_req_i)) begin
                lsu_sel_c = 1'b1;
            end else if (fetch_req_i && !fetch_flush_i) begin
                fetch_sel_c = 1'b1;
            end
        end
    end

    assign in_mem_c = (state_q == ST_MEM_FETCH) || (state_q == ST_MEM_LSU);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (lsu_sel_c && !st_misaligned) begin
                    state_d = ST_MEM_LSU;
                end else if (fetch_sel_c) begin
                    state_d = ST_MEM_FETCH;
                end
            end
            ST_MEM_FETCH, ST_MEM_LSU: begin
                if (mem_ack_i) begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            drop_q       <= 1'b0;
            is_fetch_q   <= 1'b0;
            is_store_q   <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= '0;
            lo_q         <= '0;
            dreg_q       <= '0;
            busy_dreg_q  <= '0;
            lsu_rvalid_q <= 1'b0;
            lsu_err_q    <= 1'b0;
            lsu_rdata_q  <= '0;
            fetch_data_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
        end else begin
            state_q      <= state_d;
            lsu_err_q    <= lsu_sel_c && st_misaligned;
            lsu_rvalid_q <= 1'b0;

            if (!fetch_req_i || fetch_sel_c) begin
                cnt_q <= '0;
            end else if (lsu_sel_c && (cnt_q < CNT_W'(STARVE_LIMIT))) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // A resteer while the fetch is outstanding makes its response stale.
            if (state_q == ST_RESP) begin
                drop_q <= 1'b0;
            end else if ((state_q == ST_MEM_FETCH) && fetch_flush_i) begin
                drop_q <= 1'b1;
            end

            if (lsu_sel_c && !st_misaligned) begin
                is_fetch_q  <= 1'b0;
                is_store_q  <= lsu_opcode_i[OP_STORE];
                uns_q       <= lsu_opcode_i[OP_UNSIGNED];
                size_q      <= lsu_opcode_i[1:0];
                lo_q        <= lsu_addr_i[1:0];
                dreg_q      <= lsu_dreg_i;
                busy_dreg_q <= lsu_opcode_i[OP_STORE] ? '0 : lsu_dreg_i;
                mem_req_q   <= 1'b1;
                mem_we_q    <= lsu_opcode_i[OP_STORE];
                mem_addr_q  <= lsu_addr_i[ADDR_W-1:2];
                mem_wdata_q <= st_wdata;
                mem_wmask_q <= lsu_opcode_i[OP_STORE] ? st_wmask : 4'b0000;
            end else if (fetch_sel_c) begin
                is_fetch_q  <= 1'b1;
                is_store_q  <= 1'b0;
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= fetch_addr_i[ADDR_W-1:2];
                mem_wmask_q <= 4'b0000;
            end

            if (in_mem_c && mem_ack_i) begin
                mem_req_q <= 1'b0;
                if (is_fetch_q) begin
                    fetch_data_q <= mem_rdata_i;
                end else if (!is_store_q) begin
                    lsu_rdata_q  <= ld_data;
                    lsu_rvalid_q <= 1'b1;
                end
            end

            if (state_q == ST_RESP) begin
                busy_dreg_q <= '0;
            end
        end
    end

    // Done is qualified live by flush so a resteer in the response cycle still suppresses it.
    assign fetch_done_o    = (state_q == ST_RESP) && is_fetch_q && !drop_q && !fetch_flush_i;
    assign fetch_data_o    = fetch_data_q;
    assign lsu_accept_o    = lsu_sel_c && !rst;
    assign lsu_rvalid_o    = lsu_rvalid_q;
    assign lsu_rdata_o     = lsu_rdata_q;
    assign lsu_rdreg_o     = dreg_q;
    assign lsu_err_o       = lsu_err_q;
    assign lsu_busy_dreg_o = busy_dreg_q;
    assign mem_req_o       = mem_req_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign mem_wmask_o     = mem_wmask_q;

endmodule

// File: tb/tb_dumbrv_mem_arb.sv
// Directed bench for dumbrv_mem_arb: LSU vector table plus arbitration, flush and reset sequences.
module tb_dumbrv_mem_arb;

    localparam int unsigned ADDR_W = 24;

    logic              clk;
    logic              rst;
    logic              fetch_req_i;
    logic [ADDR_W-1:0] fetch_addr_i;
    logic              fetch_flush_i;
    logic              fetch_done_o;
    logic [31:0]       fetch_data_o;
    logic              lsu_valid_i;
    logic [3:0]        lsu_opcode_i;
    logic [31:0]       lsu_addr_i;
    logic [31:0]       lsu_data_i;
    logic [3:0]        lsu_dreg_i;
    logic              lsu_accept_o;
    logic              lsu_rvalid_o;
    logic [31:0]       lsu_rdata_o;
    logic [3:0]        lsu_rdreg_o;
    logic              lsu_err_o;
    logic [3:0]        lsu_busy_dreg_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-3:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_wmask_o;
    logic              mem_ack_i;
    logic [31:0]       mem_rdata_i;

    dumbrv_mem_arb #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_req_i     (fetch_req_i),
        .fetch_addr_i    (fetch_addr_i),
        .fetch_flush_i   (fetch_flush_i),
        .fetch_done_o    (fetch_done_o),
        .fetch_data_o    (fetch_data_o),
        .lsu_valid_i     (lsu_valid_i),
        .lsu_opcode_i    (lsu_opcode_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_dreg_i      (lsu_dreg_i),
        .lsu_accept_o    (lsu_accept_o),
        .lsu_rvalid_o    (lsu_rvalid_o),
        .lsu_rdata_o     (lsu_rdata_o),
        .lsu_rdreg_o     (lsu_rdreg_o),
        .lsu_err_o       (lsu_err_o),
        .lsu_busy_dreg_o (lsu_busy_dreg_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_wmask_o     (mem_wmask_o),
        .mem_ack_i       (mem_ack_i),
        .mem_rdata_i     (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: acks after ack_delay waiting cycles, logs acked word addresses.
    int unsigned       ack_delay;
    int unsigned       mem_wait;
    logic [31:0]       mem_word;
    logic              log_en;
    logic [ADDR_W-3:0] mem_log[$];

    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        mem_wait    = 0;
        forever begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (mem_req_o && !rst) begin
                if (mem_wait >= ack_delay) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_word;
                    mem_wait    = 0;
                    if (log_en) mem_log.push_back(mem_addr_o);
                end else begin
                    mem_wait++;
                end
            end else begin
                mem_wait = 0;
            end
        end
    end

    typedef struct {
        logic [3:0]        op;
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic [3:0]        dreg;
        logic [31:0]       mword;
        logic              exp_we;
        logic [ADDR_W-3:0] exp_maddr;
        logic [3:0]        exp_mask;
        logic [31:0]       exp_wdata;
        logic              exp_rv;
        logic [31:0]       exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        lsu_valid_i  = 1'b1;
        lsu_opcode_i = v.op;
        lsu_addr_i   = v.addr;
        lsu_data_i   = v.wdata;
        lsu_dreg_i   = v.dreg;
        mem_word     = v.mword;
        #1;
        chk({tag, "_accept"}, 32'(lsu_accept_o), 32'd1);
        @(negedge clk);
        lsu_valid_i = 1'b0;
        chk({tag, "_mem_req"}, 32'(mem_req_o), 32'd1);
        chk({tag, "_mem_we"}, 32'(mem_we_o), 32'(v.exp_we));
        chk({tag, "_mem_addr"}, 32'(mem_addr_o), 32'(v.exp_maddr));
        chk({tag, "_mem_wmask"}, 32'(mem_wmask_o), 32'(v.exp_mask));
        if (v.exp_we) chk({tag, "_mem_wdata"}, mem_wdata_o, v.exp_wdata);
        chk({tag, "_busy"}, 32'(lsu_busy_dreg_o), v.exp_rv ? 32'(v.dreg) : 32'd0);
        @(negedge clk);
        chk({tag, "_rvalid"}, 32'(lsu_rvalid_o), 32'(v.exp_rv));
        if (v.exp_rv) begin
            chk({tag, "_rdata"}, lsu_rdata_o, v.exp_rdata);
            chk({tag, "_rdreg"}, 32'(lsu_rdreg_o), 32'(v.dreg));
        end
        chk({tag, "_req_low"}, 32'(mem_req_o), 32'd0);
        @(negedge clk);
        chk({tag, "_rvalid_end"}, 32'(lsu_rvalid_o), 32'd0);
        chk({tag, "_busy_end"}, 32'(lsu_busy_dreg_o), 32'd0);
    endtask

    initial begin
        int cyc;
        int done_cnt;
        int ack_cnt;
        logic [31:0] mis_addr[2];
        logic [3:0]  mis_op[2];

        rst = 1'b1;
        fetch_req_i = 1'b0; fetch_addr_i = '0; fetch_flush_i = 1'b0;
        lsu_valid_i = 1'b0; lsu_opcode_i = '0; lsu_addr_i = '0; lsu_data_i = '0; lsu_dreg_i = '0;
        ack_delay = 0; mem_word = '0; log_en = 1'b0;

        //            op     addr      wdata         dreg  mword         we    maddr    mask   wdata         rv    rdata
        vecs[0] = '{4'h0, 32'h013, 32'h0,        4'd5,  32'h80FF7F00, 1'b0, 22'h04, 4'h0, 32'h0,        1'b1, 32'hFFFFFF80};
        vecs[1] = '{4'h4, 32'h013, 32'h0,        4'd6,  32'h80FF7F00, 1'b0, 22'h04, 4'h0, 32'h0,        1'b1, 32'h00000080};
        vecs[2] = '{4'h9, 32'h102, 32'h1234ABCD, 4'd2,  32'h0,        1'b1, 22'h40, 4'hC, 32'hABCD0000, 1'b0, 32'h0};
        vecs[3] = '{4'h1, 32'h102, 32'h0,        4'd7,  32'h80FF7F00, 1'b0, 22'h40, 4'h0, 32'h0,        1'b1, 32'hFFFF80FF};
        vecs[4] = '{4'h5, 32'h100, 32'h0,        4'd3,  32'h80FF7F00, 1'b0, 22'h40, 4'h0, 32'h0,        1'b1, 32'h00007F00};
        vecs[5] = '{4'h2, 32'h204, 32'h0,        4'd15, 32'hDEADBEEF, 1'b0, 22'h81, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[6] = '{4'h8, 32'h011, 32'h123456A5, 4'd4,  32'h0,        1'b1, 22'h04, 4'h2, 32'h3456A500, 1'b0, 32'h0};
        vecs[7] = '{4'hA, 32'h020, 32'hCAFEF00D, 4'd8,  32'h0,        1'b1, 22'h08, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
        vecs[8] = '{4'h0, 32'h012, 32'h0,        4'd1,  32'h80FF7F00, 1'b0, 22'h04, 4'h0, 32'h0,        1'b1, 32'hFFFFFFFF};

        #12;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_fetch_done", 32'(fetch_done_o), 32'd0);
        chk("rst_accept", 32'(lsu_accept_o), 32'd0);
        chk("rst_rvalid", 32'(lsu_rvalid_o), 32'd0);
        chk("rst_err", 32'(lsu_err_o), 32'd0);
        chk("rst_busy", 32'(lsu_busy_dreg_o), 32'd0);
        chk("rst_wmask", 32'(mem_wmask_o), 32'd0);
        chk("rst_fetch_data", fetch_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Misaligned LW to 0x6 and SH to 0x101: accepted, error next cycle, no memory access.
        mis_addr[0] = 32'h006; mis_op[0] = 4'h2;
        mis_addr[1] = 32'h101; mis_op[1] = 4'h9;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            lsu_valid_i = 1'b1; lsu_opcode_i = mis_op[i]; lsu_addr_i = mis_addr[i]; lsu_dreg_i = 4'd9;
            #1;
            chk("mis_accept", 32'(lsu_accept_o), 32'd1);
            @(negedge clk);
            lsu_valid_i = 1'b0;
            chk("mis_err", 32'(lsu_err_o), 32'd1);
            chk("mis_no_req", 32'(mem_req_o), 32'd0);
            @(negedge clk);
            chk("mis_err_end", 32'(lsu_err_o), 32'd0);
            chk("mis_no_req2", 32'(mem_req_o), 32'd0);
            chk("mis_busy", 32'(lsu_busy_dreg_o), 32'd0);
        end

        // Both requesters held: LSU x4 then fetch x1, repeating.
        ack_delay = 1; mem_log.delete(); log_en = 1'b1; mem_word = 32'h0;
        @(negedge clk);
        fetch_req_i = 1'b1; fetch_addr_i = 24'h000100;
        lsu_valid_i = 1'b1; lsu_opcode_i = 4'h2; lsu_addr_i = 32'h200; lsu_dreg_i = 4'd2;
        cyc = 0;
        while (mem_log.size() < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        fetch_req_i = 1'b0; lsu_valid_i = 1'b0; log_en = 1'b0;
        chk("starve_grants", 32'(mem_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < mem_log.size(); i++)
            chk($sformatf("starve_grant%0d", i), 32'(mem_log[i]), (i % 5 == 4) ? 32'h40 : 32'h80);
        repeat (6) @(negedge clk);

        // Flush while the fetch is outstanding: transaction completes, response dropped.
        ack_delay = 3; mem_word = 32'hBAD0BAD0;
        @(negedge clk);
        fetch_req_i = 1'b1; fetch_addr_i = 24'h000300;
        @(negedge clk);
        chk("flush_req_up", 32'(mem_req_o), 32'd1);
        fetch_flush_i = 1'b1; fetch_req_i = 1'b0;
        @(negedge clk);
        fetch_flush_i = 1'b0;
        done_cnt = 0; ack_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (fetch_done_o) done_cnt++;
            if (mem_ack_i) ack_cnt++;
        end
        chk("flush_no_done", 32'(done_cnt), 32'd0);
        chk("flush_ack_once", 32'(ack_cnt), 32'd1);
        chk("flush_req_low", 32'(mem_req_o), 32'd0);

        ack_delay = 0; mem_word = 32'h11223344;
        @(negedge clk);
        fetch_req_i = 1'b1; fetch_addr_i = 24'h000400;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!fetch_done_o && cyc < 20);
        fetch_req_i = 1'b0;
        chk("refetch_latency", 32'(cyc), 32'd2);
        chk("refetch_data", fetch_data_o, 32'h11223344);
        repeat (2) @(negedge clk);

        // Reset in the middle of an LSU transaction, then a clean zero-wait fetch.
        ack_delay = 5;
        @(negedge clk);
        lsu_valid_i = 1'b1; lsu_opcode_i = 4'h2; lsu_addr_i = 32'h40; lsu_dreg_i = 4'd9;
        @(negedge clk);
        lsu_valid_i = 1'b0;
        chk("rstmid_req_up", 32'(mem_req_o), 32'd1);
        chk("rstmid_busy", 32'(lsu_busy_dreg_o), 32'd9);
        rst = 1'b1;
        #1;
        chk("rstmid_req_low", 32'(mem_req_o), 32'd0);
        chk("rstmid_busy_clr", 32'(lsu_busy_dreg_o), 32'd0);
        @(negedge clk);
        rst = 1'b0; ack_delay = 0;
        @(negedge clk);
        fetch_req_i = 1'b1; fetch_addr_i = 24'h000500; mem_word = 32'h55AA55AA;
        @(negedge clk);
        chk("post_rst_req", 32'(mem_req_o), 32'd1);
        chk("post_rst_addr", 32'(mem_addr_o), 32'h140);
        chk("post_rst_done_early", 32'(fetch_done_o), 32'd0);
        @(negedge clk);
        chk("post_rst_done", 32'(fetch_done_o), 32'd1);
        chk("post_rst_data", fetch_data_o, 32'h55AA55AA);
        fetch_req_i = 1'b0;
        @(negedge clk);
        chk("post_rst_done_end", 32'(fetch_done_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dumbrv_mem_arb.md
Name: dumbrv_mem_arb

Overview:
Shares the single external memory port between the instruction fetcher and the work unit's LSU submissions.
- Grants one transaction at a time, with LSU priority and a bounded anti-starvation rule for fetch.
- Aligns store data and byte masks; extracts and extends load data.
- Returns load results tagged with the destination register, for write-back into the register file.
- Drops fetch responses that a resteer has made stale.

Parameters:
ADDR_W, 24, memory byte-address width (mem_addr_o is word address ADDR_W-2 bits).
STARVE_LIMIT, 4, max consecutive LSU grants while fetch waits (1..15).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
fetch_req_i  in  1  level request; hold with stable fetch_addr_i until fetch_done_o or flush
fetch_addr_i  in  ADDR_W  fetch byte address, bits[1:0] ignored
fetch_flush_i  in  1  resteer pulse; discard any in-flight fetch response
fetch_done_o  out  1  one-cycle pulse, fetch_data_o valid
fetch_data_o  out  32  fetched word
lsu_valid_i  in  1  LSU submission valid
lsu_opcode_i  in  4  [3]=store, [2]=unsigned load, [1:0]=size 0 byte/1 half/2 word
lsu_addr_i  in  32  byte address (low ADDR_W bits used)
lsu_data_i  in  32  store data, right-aligned
lsu_dreg_i  in  4  load destination register
lsu_accept_o  out  1  combinational; submission taken this cycle
lsu_rvalid_o  out  1  one-cycle pulse, load result valid
lsu_rdata_o  out  32  extended load result
lsu_rdreg_o  out  4  destination of lsu_rdata_o
lsu_err_o  out  1  one-cycle pulse, misaligned access rejected
lsu_busy_dreg_o  out  4  dreg of load in flight, 0 if none (feeds decode stall)
mem_req_o  out  1  held high until mem_ack_i
mem_we_o  out  1  write transaction
mem_addr_o  out  ADDR_W-2  word address
mem_wdata_o  out  32  lane-shifted store data
mem_wmask_o  out  4  byte enables, 0000 on reads
mem_ack_i  in  1  single-cycle completion; mem_rdata_i valid same cycle
mem_rdata_i  in  32  read word

Behaviour:
- Reset (async, immediate): state IDLE, starve count 0, drop flag 0. All outputs 0, including mem_req_o. An abandoned memory transaction is the memory's concern.
- States: IDLE, MEM_FETCH, MEM_LSU, RESP.
- IDLE selection:
  - If lsu_valid_i and (count<STARVE_LIMIT or !fetch_req_i): select LSU. Otherwise, if fetch_req_i and !fetch_flush_i: select fetch.
  - LSU selected: lsu_accept_o=1 the same cycle.
  - Misaligned LSU access (half with addr[0]=1, word with addr[1:0]!=0): accepted, no memory access, lsu_err_o pulses next cycle, stays IDLE.
  - Aligned LSU access: latch payload, go to MEM_LSU.
  - Fetch selected: latch address, go to MEM_FETCH.
- Starve counter:
  - Increments on each LSU accept while fetch_req_i=1, saturating at STARVE_LIMIT.
  - Clears on fetch grant or whenever fetch_req_i=0.
- MEM_*:
  - mem_req_o=1 from the cycle after grant, payload stable.
  - On mem_ack_i, latch rdata and go to RESP. mem_req_o is low the following cycle.
- RESP (one cycle):
  - Fetch: fetch_done_o=1 unless drop flag set or fetch_flush_i is high this cycle.
  - LSU load: lsu_rvalid_o=1. Store: no response.
  - Return to IDLE; new grant possible the next cycle.
- Minimum latency: request seen at cycle N → mem_req_o at N+1 → ack at N+1 → response pulse at N+2.
- fetch_flush_i:
  - Ignored in IDLE with no grant.
  - In MEM_FETCH, or on the ack cycle, sets the drop flag. The flag clears on entry to IDLE.
  - Never aborts the memory transaction.
- Stores: mem_wmask_o = size mask << addr[1:0]; mem_wdata_o = data << 8*addr[1:0].
- Loads: word >> 8*addr[1:0], truncated to size, sign-extended unless opcode[2].
- lsu_busy_dreg_o = latched dreg from accept through the RESP cycle for loads, else 0.

Decomposition:
- dumbrv_pkg: LSU opcode field positions and size encodings, state encoding.
- One sub-module, dumbrv_mem_align: combinational store mask/shift and load extract/extend.

Test Plan:
- LB from addr 0x13 with mem word 0x80FF7F00: response lsu_rdata_o=0xFFFFFF80. LBU from the same address gives 0x00000080, with lsu_rdreg_o=dreg.
- SH of 0x1234ABCD to 0x102: mem_we_o=1, mem_addr_o=0x40, mem_wmask_o=1100, mem_wdata_o=0xABCD0000; no lsu_rvalid_o.
- fetch_req_i and lsu_valid_i held continuously, STARVE_LIMIT=4, ack 1 cycle after req: grants go LSU×4, fetch×1, repeating.
- fetch_flush_i during MEM_FETCH with ack 3 cycles later: fetch_done_o never pulses; next fetch to a new address completes normally.
- LW to 0x6: lsu_accept_o=1, lsu_err_o=1 next cycle, mem_req_o stays 0.
- rst asserted mid-MEM_LSU: mem_req_o low immediately. After release, a single fetch completes with fetch_done_o 2 cycles after request with 0-wait ack.
